// File: rtl/prince_slayer_seq.sv
// Sequential PRINCE S-layer: substitutes a 64-bit state one nibble per cycle through a shared S-box.
// Define SLAYER_SEQ_DUAL_EN to use two S-box units (two nibbles per cycle, half the RUN length).

module prince_slayer_lane (
    input  logic       inv_i,
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);
    always_comb begin
        y_o = 4'h0;
        if (!inv_i) begin
            case (x_i)
                4'h0: y_o = 4'hB;  4'h1: y_o = 4'hF;  4'h2: y_o = 4'h3;  4'h3: y_o = 4'h2;
                4'h4: y_o = 4'hA;  4'h5: y_o = 4'hC;  4'h6: y_o = 4'h9;  4'h7: y_o = 4'h1;
                4'h8: y_o = 4'h6;  4'h9: y_o = 4'h7;  4'hA: y_o = 4'h8;  4'hB: y_o = 4'h0;
                4'hC: y_o = 4'hE;  4'hD: y_o = 4'h5;  4'hE: y_o = 4'hD;  default: y_o = 4'h4;
            endcase
        end else begin
            case (x_i)
                4'h0: y_o = 4'hB;  4'h1: y_o = 4'h7;  4'h2: y_o = 4'h3;  4'h3: y_o = 4'h2;
                4'h4: y_o = 4'hF;  4'h5: y_o = 4'hD;  4'h6: y_o = 4'h8;  4'h7: y_o = 4'h9;
                4'h8: y_o = 4'hA;  4'h9: y_o = 4'h6;  4'hA: y_o = 4'h4;  4'hB: y_o = 4'h0;
                4'hC: y_o = 4'h5;  4'hD: y_o = 4'hE;  4'hE: y_o = 4'hC;  default: y_o = 4'h1;
            endcase
        end
    end
endmodule

module prince_slayer_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        inv,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] data_out
);
`ifdef SLAYER_SEQ_DUAL_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam int CW = $clog2(16 / LANES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                inv_q;
    logic                fin_q;
    logic                busy_q;
    logic                done_q;
    logic [63:0]         work_q;
    logic [63:0]         work_d;
    logic [3:0]          nib_idx [LANES];
    logic [LANES-1:0][3:0] lane_in;
    logic [LANES-1:0][3:0] lane_out;

    // Lane l of step c handles nibble c*LANES + l, so lowest nibbles go first.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign nib_idx[l] = 4'(int'(cnt_q) * LANES + l);
        assign lane_in[l] = work_q[{nib_idx[l], 2'b00} +: 4];
        prince_slayer_lane u_lane (
            .inv_i (inv_q),
            .x_i   (lane_in[l]),
            .y_o   (lane_out[l])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++)
            work_d[{nib_idx[l], 2'b00} +: 4] = lane_out[l];
    end

    // fin_q marks that every nibble has been written; the following edge enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            work_q  <= 64'h0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        work_q  <= data_in;
                        inv_q   <= inv;
                        cnt_q   <= '0;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!fin_q) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == {CW{1'b1}})
                            fin_q <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = work_q;
endmodule

// File: tb/tb_prince_slayer_seq.sv
// Directed bench for prince_slayer_seq: reset, known vectors, round trip, ignored starts,
// continuous-start back-to-back operation and mid-run reset.
module tb_prince_slayer_seq;
`ifdef SLAYER_SEQ_DUAL_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 17;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        inv;
    logic [63:0] data_in;
    logic        busy;
    logic        done;
    logic [63:0] data_out;

    int tests = 0;
    int fails = 0;

    prince_slayer_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inv      (inv),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    logic [3:0] fwd_tab [16] = '{4'hB,4'hF,4'h3,4'h2,4'hA,4'hC,4'h9,4'h1,
                                 4'h6,4'h7,4'h8,4'h0,4'hE,4'h5,4'hD,4'h4};
    logic [3:0] inv_tab [16] = '{4'hB,4'h7,4'h3,4'h2,4'hF,4'hD,4'h8,4'h9,
                                 4'hA,4'h6,4'h4,4'h0,4'h5,4'hE,4'hC,4'h1};

    function automatic logic [63:0] ref_slayer(input logic [63:0] d, input logic iv);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 16; k++)
            r[4*k +: 4] = iv ? inv_tab[d[4*k +: 4]] : fwd_tab[d[4*k +: 4]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept edge T, then count edges until done is seen #1 after an edge (bounded).
    task automatic run_op(input logic [63:0] d, input logic iv, input int poke,
                          output logic [63:0] res, output int lat);
        data_in = d; inv = iv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = ~d; inv = ~iv;
        lat = 0;
        while (lat < 40) begin
            if (lat == poke) begin
                start = 1'b1; data_in = 64'hFFFF_FFFF_FFFF_FFFF; inv = ~iv;
            end
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (done) break;
        end
        res = data_out;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] held;
        logic [63:0] acc_d;
        logic        acc_i;
        logic [63:0] kv;
        int          lat;
        int          ndone;

        rst_n = 1'b0; start = 1'b0; inv = 1'b0; data_in = 64'h0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_data", data_out, 64'h0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;

        // all-zero input
        run_op(64'h0, 1'b0, -1, res, lat);
        check("zero_lat", 64'(lat), 64'(LAT));
        check("zero_data", res, 64'hBBBB_BBBB_BBBB_BBBB);
        check("zero_busy_at_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("zero_done_single", 64'(done), 64'd0);
        check("zero_hold", data_out, 64'hBBBB_BBBB_BBBB_BBBB);

        // known forward/inverse vectors; the second run also pokes start mid-RUN
        run_op(64'h0123_4567_89AB_CDEF, 1'b0, -1, res, lat);
        check("fwd_vec", res, 64'hBF32_AC91_6780_E5D4);
        run_op(64'h0123_4567_89AB_CDEF, 1'b1, 5, res, lat);
        check("inv_vec_ignore_start", res, 64'hB732_FD89_A640_5EC1);
        check("inv_vec_lat", 64'(lat), 64'(LAT));

        // round trip
        run_op(64'hDEAD_BEEF_0123_4567, 1'b0, -1, res, lat);
        check("rt_fwd", res, 64'h5D85_0DD4_BF32_AC91);
        held = res;
        repeat (4) @(posedge clk);
        #1;
        check("rt_stable", data_out, held);
        check("rt_idle_busy", 64'(busy), 64'd0);
        run_op(held, 1'b1, -1, res, lat);
        check("rt_inv", res, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk); #1;

        // start held high with data changing every cycle: accepts at k%(LAT+1)==0
        acc_d = '0; acc_i = 1'b0;
        for (int k = 0; k < 3 * (LAT + 1); k++) begin
            kv = 64'(k);
            data_in = 64'hFEDC_BA98_7654_3210 + kv * 64'h0101_0101_0101_0101;
            inv = kv[1];
            start = 1'b1;
            if (k % (LAT + 1) == 0) begin
                acc_d = data_in; acc_i = inv;
            end
            @(posedge clk); #1;
            if (k % (LAT + 1) == LAT) begin
                check("b2b_done", 64'(done), 64'd1);
                check("b2b_data", data_out, ref_slayer(acc_d, acc_i));
            end else if (k % (LAT + 1) == 0) begin
                check("b2b_busy_after_accept", 64'(busy), 64'd1);
            end
            if (k == 3 * (LAT + 1) - 1) start = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b_idle", 64'(busy), 64'd0);

        // reset at RUN counter = 7
        data_in = 64'h0123_4567_89AB_CDEF; inv = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", data_out, 64'h0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("rst_no_done", 64'(ndone), 64'd0);
        run_op(64'h0, 1'b0, -1, res, lat);
        check("rst_fresh_data", res, 64'hBBBB_BBBB_BBBB_BBBB);
        check("rst_fresh_lat", 64'(lat), 64'(LAT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
